// File: rtl/pc_redirect_ctrl.sv
// Next-PC select with prioritised redirects held across fetch stalls.
// Optional misaligned-fetch report enabled by PC_ALIGN_CHECK_EN.
module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        if_ready,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic [31:0] npc_o,
  output logic        pc_wr_o,
  output logic        redirect_o,
  output logic        pend_o,
  output logic        adel_o,
  output logic [31:0] badvaddr_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_tgt;
  logic [1:0]  pend_pri;
  logic        any_req;
  logic [1:0]  win_pri;
  logic [31:0] win_tgt;
  logic        take;
  logic        cap;
  logic [31:0] seq_pc;

  assign seq_pc = pc_i + 32'd4;

  always_comb begin
    any_req = 1'b1;
    win_pri = 2'd0;
    win_tgt = 32'd0;
    priority case (1'b1)
      exc_valid: begin
        win_pri = 2'd3;
        win_tgt = exc_target;
      end
      eret_valid: begin
        win_pri = 2'd2;
        win_tgt = epc;
      end
      br_valid: begin
        win_pri = 2'd1;
        win_tgt = br_target;
      end
      jmp_valid: begin
        win_pri = 2'd0;
        win_tgt = jmp_target;
      end
      default: any_req = 1'b0;
    endcase
  end

  // In HOLD a newcomer only wins if it ranks at least as high as the pending one
  assign take = any_req &&
                ((state == RUN) || (win_pri >= pend_pri));
  assign cap  = !rst && take && !if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_tgt <= 32'd0;
      pend_pri <= 2'd0;
    end else if (cap) begin
      pend_tgt <= win_tgt;
      pend_pri <= win_pri;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (any_req && !if_ready) state_nxt = HOLD;
      HOLD: if (if_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    npc_o      = seq_pc;
    pc_wr_o    = 1'b0;
    redirect_o = 1'b0;
    if (!rst) begin
      pc_wr_o    = if_ready;
      redirect_o = take;
      if (if_ready) begin
        if (take) begin
          npc_o = win_tgt;
        end else if (state == HOLD) begin
          npc_o = pend_tgt;
        end
      end
    end
  end

  assign pend_o = (state == HOLD) && !rst;

`ifdef PC_ALIGN_CHECK_EN
  assign adel_o     = pc_wr_o && (npc_o[1:0] != 2'b00);
  assign badvaddr_o = adel_o ? npc_o : 32'd0;
`else
  assign adel_o     = 1'b0;
  assign badvaddr_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed cases plus random
// traffic against a queue-free behavioural model of the redirect rules.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        if_ready;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        eret_valid;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic [31:0] npc_o;
  logic        pc_wr_o;
  logic        redirect_o;
  logic        pend_o;
  logic        adel_o;
  logic [31:0] badvaddr_o;

  int n_chk  = 0;
  int n_pass = 0;

  bit          m_has;
  logic [31:0] m_tgt;
  int          m_pri;

  logic [31:0] e_npc;
  bit          e_npc_ok;
  bit          e_wr;
  bit          e_red;
  bit          e_adel;
  logic [31:0] e_bad;
  bit          w_any;
  int          w_pri;
  logic [31:0] w_tgt;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .if_ready   (if_ready),
    .exc_valid  (exc_valid),
    .exc_target (exc_target),
    .eret_valid (eret_valid),
    .epc        (epc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .npc_o      (npc_o),
    .pc_wr_o    (pc_wr_o),
    .redirect_o (redirect_o),
    .pend_o     (pend_o),
    .adel_o     (adel_o),
    .badvaddr_o (badvaddr_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Model: highest valid index in a priority-indexed table wins.
  task automatic model_eval();
    bit          v[4];
    logic [31:0] t[4];
    bit          take;
    v = '{jmp_valid, br_valid, eret_valid, exc_valid};
    t = '{jmp_target, br_target, epc, exc_target};
    w_any = 0;
    w_pri = 0;
    w_tgt = 0;
    for (int p = 3; p >= 0; p--) begin
      if (v[p] && !w_any) begin
        w_any = 1;
        w_pri = p;
        w_tgt = t[p];
      end
    end
    take     = w_any && (!m_has || w_pri >= m_pri);
    e_npc    = pc_i + 32'd4;
    e_npc_ok = 1;
    e_wr     = 0;
    e_red    = 0;
    if (!rst) begin
      e_wr  = if_ready;
      e_red = take;
      if (if_ready) begin
        if (take) e_npc = w_tgt;
        else if (m_has) e_npc = m_tgt;
      end else if (m_has) begin
        e_npc_ok = 0;
      end
    end
`ifdef PC_ALIGN_CHECK_EN
    e_adel = e_wr && (e_npc % 4 != 0);
`else
    e_adel = 0;
`endif
    e_bad = e_adel ? e_npc : 32'd0;
  endtask

  task automatic model_tick();
    bit take;
    take = w_any && (!m_has || w_pri >= m_pri);
    if (rst) begin
      m_has = 0;
      m_tgt = 0;
      m_pri = 0;
    end else if (if_ready) begin
      m_has = 0;
    end else if (take) begin
      m_has = 1;
      m_tgt = w_tgt;
      m_pri = w_pri;
    end
  endtask

  task automatic drive(input bit r, input bit rdy,
                       input logic [31:0] pc,
                       input bit ev, input logic [31:0] et,
                       input bit rv, input logic [31:0] ep,
                       input bit bv, input logic [31:0] bt,
                       input bit jv, input logic [31:0] jt);
    @(negedge clk);
    rst        = r;
    if_ready   = rdy;
    pc_i       = pc;
    exc_valid  = ev;
    exc_target = et;
    eret_valid = rv;
    epc        = ep;
    br_valid   = bv;
    br_target  = bt;
    jmp_valid  = jv;
    jmp_target = jt;
    #1;
    model_eval();
    if (e_npc_ok) chk("npc", npc_o, e_npc);
    chk("pc_wr", 32'(pc_wr_o), 32'(e_wr));
    chk("redirect", 32'(redirect_o), 32'(e_red));
    chk("pend", 32'(pend_o), 32'(m_has && !rst));
    chk("adel", 32'(adel_o), 32'(e_adel));
    chk("badvaddr", badvaddr_o, e_bad);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic idle(input bit rdy, input logic [31:0] pc);
    drive(0, rdy, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rtgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    m_has = 0;
    m_tgt = 0;
    m_pri = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'hBFC0_0000, 1, 32'h1, 1, 32'h2, 1, 32'h3, 1, 32'h4);
      chk("rst_wr", 32'(pc_wr_o), 32'd0);
      chk("rst_npc", npc_o, 32'hBFC0_0004);
      tick();
    end

    idle(1, 32'hBFC0_0000);
    chk("seq_npc", npc_o, 32'hBFC0_0004);
    chk("seq_red", 32'(redirect_o), 32'd0);
    tick();

    drive(0, 1, 32'hBFC0_0004, 1, 32'hBFC0_0380, 0, 0,
          1, 32'h8000_1000, 0, 0);
    chk("exc_npc", npc_o, 32'hBFC0_0380);
    chk("exc_red", 32'(redirect_o), 32'd1);
    tick();

    drive(0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h8000_2000, 0, 0);
    chk("cap_red", 32'(redirect_o), 32'd1);
    tick();
    idle(0, 32'h8000_0000);
    chk("hold_pend1", 32'(pend_o), 32'd1);
    tick();
    idle(0, 32'h8000_0000);
    chk("hold_pend2", 32'(pend_o), 32'd1);
    tick();
    idle(1, 32'h8000_0000);
    chk("rel_npc", npc_o, 32'h8000_2000);
    chk("rel_wr", 32'(pc_wr_o), 32'd1);
    tick();
    idle(1, 32'h8000_2000);
    chk("rel_pend", 32'(pend_o), 32'd0);
    tick();

    drive(0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h8000_3000, 0, 0);
    tick();
    drive(0, 0, 32'h8000_0000, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
    chk("ovr_red", 32'(redirect_o), 32'd1);
    tick();
    drive(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0500);
    chk("drop_npc", npc_o, 32'h8000_0100);
    chk("drop_red", 32'(redirect_o), 32'd0);
    tick();

    idle(1, 32'hFFFF_FFFC);
    chk("wrap_npc", npc_o, 32'h0000_0000);
    tick();
    drive(0, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h8000_4000, 0, 0);
    tick();
    idle(0, 32'h8000_0000);
    chk("pre_rst_pend", 32'(pend_o), 32'd1);
    tick();
    drive(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(1, 32'h8000_0000);
    chk("lost_pend", 32'(pend_o), 32'd0);
    chk("lost_npc", npc_o, 32'h8000_0004);
    tick();

    drive(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0002);
`ifdef PC_ALIGN_CHECK_EN
    chk("align_adel", 32'(adel_o), 32'd1);
    chk("align_bad", badvaddr_o, 32'h8000_0002);
`else
    chk("align_adel", 32'(adel_o), 32'd0);
`endif
    tick();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : rtgt(),
            $urandom_range(0, 5) == 0, rtgt(),
            $urandom_range(0, 4) == 0, rtgt(),
            $urandom_range(0, 3) == 0, rtgt(),
            $urandom_range(0, 3) == 0, rtgt());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port pc_i  input  32  current fetch PC held by the PC register.
REQ-004 SHALL have port if_ready  input  1  fetch stage accepts a new PC this cycle.
REQ-005 SHALL have port exc_valid / exc_target  input  1/32  exception entry request and vector.
REQ-006 SHALL have port eret_valid / epc  input  1/32  ERET request and return address.
REQ-007 SHALL have port br_valid / br_target  input  1/32  EX-stage branch-resolve redirect.
REQ-008 SHALL have port jmp_valid / jmp_target  input  1/32  ID-stage jump redirect.
REQ-009 SHALL have port npc_o  output  32  next PC driven to the PC register.
REQ-010 SHALL have port pc_wr_o  output  1  PC register write enable.
REQ-011 SHALL have port redirect_o  output  1  one-cycle flush pulse to the IF stage on redirect acceptance.
REQ-012 SHALL have port pend_o  output  1  high while a redirect is held pending.
REQ-013 SHALL have port adel_o / badvaddr_o  output  1/32  misaligned-fetch report (see Configuration).

Function
REQ-014 SHALL use fixed priority: exc (3) > eret (2) > br (1) > jmp (0) > sequential; the winner is the highest-priority valid request.
REQ-015 SHALL implement FSM states RUN and HOLD; stored pending target (32b) and pending priority (2b).
REQ-016 In RUN with if_ready=1: pc_wr_o=1; npc_o = winner target, or pc_i+4 (modulo 2^32) if no request.
REQ-017 In RUN with if_ready=1 and any request: redirect_o=1 in the same cycle (combinational, zero latency).
REQ-018 In RUN with if_ready=0 and no request: pc_wr_o=0; npc_o=pc_i+4; stay RUN.
REQ-019 In RUN with if_ready=0 and a request: pc_wr_o=0; capture winner target/priority; go HOLD next cycle; redirect_o=1 in capture cycle.
REQ-020 In HOLD with if_ready=0: a new winner with priority >= pending priority overwrites the pending entry; lower-priority requests are dropped; redirect_o=1 on overwrite only.
REQ-021 In HOLD with if_ready=1: pc_wr_o=1; npc_o = new winner if priority >= pending, else pending target; go RUN; redirect_o=1 only if a new winner is used.
REQ-022 pend_o SHALL equal (state==HOLD).
REQ-023 Simultaneous requests in one cycle SHALL resolve by REQ-014 only; lower ones are discarded, not queued.
REQ-024 Non-winning target inputs SHALL NOT affect any output.

Reset
REQ-025 On rst=1: state=RUN, pending target=0, pending priority=0; rst dominates all requests and if_ready.
REQ-026 While rst=1: pc_wr_o=0, redirect_o=0, pend_o=0, adel_o=0, badvaddr_o=0; npc_o=pc_i+4.
REQ-027 rst asserted in HOLD SHALL discard the pending redirect.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: when pc_wr_o=1 and npc_o[1:0]!=0, adel_o=1 and badvaddr_o=npc_o that cycle; PC is still written.
REQ-029 Macro PC_ALIGN_CHECK_EN undefined: adel_o and badvaddr_o tied to 0, no check logic.

Verification
REQ-030 pc_i=0xBFC00000, if_ready=1, no requests -> npc_o=0xBFC00004, pc_wr_o=1, redirect_o=0.
REQ-031 exc_valid(0xBFC00380)+br_valid(0x80001000), if_ready=1 -> npc_o=0xBFC00380, redirect_o=1 same cycle.
REQ-032 if_ready=0, br_valid(0x80002000) one cycle; 2 cycles later if_ready=1 -> pend_o=1 in between; then npc_o=0x80002000, pc_wr_o=1, pend_o=0.
REQ-033 In HOLD with pending br, eret_valid(epc=0x80000100) while if_ready=0 then jmp_valid while if_ready=1 -> npc_o=0x80000100; jmp dropped.
REQ-034 pc_i=0xFFFFFFFC, if_ready=1, no requests -> npc_o=0x00000000; rst in HOLD -> pend_o=0 next cycle, pending lost.
REQ-035 With PC_ALIGN_CHECK_EN, jmp_target=0x80000002, if_ready=1 -> adel_o=1, badvaddr_o=0x80000002; without macro adel_o=0.
